// File: rtl/ahb_arb_pkg.sv
// Shared types and index widths for the round-robin AHB arbiter/interconnect.
package ahb_arb_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_t;

  localparam int MAX_PORTS = 16;
  localparam int MIDX_W    = $clog2(MAX_PORTS);
  // One extra code point beyond the largest slave index marks "no slave".
  localparam int SIDX_W    = $clog2(MAX_PORTS + 1);
  localparam logic [SIDX_W-1:0] SLV_NONE = '1;

endpackage

// File: rtl/ahb_rr_picker.sv
// Rotating-priority picker: first requester found scanning upward from last+1, with wrap.
module ahb_rr_picker #(
  parameter int NUM_M = 8,
  parameter int IW    = $clog2(NUM_M)
) (
  input  logic [NUM_M-1:0] req,
  input  logic [IW-1:0]    last,
  output logic [IW-1:0]    winner,
  output logic             valid
);

  always_comb begin
    int          idx;
    logic [IW-1:0] idx_l;
    idx    = 0;
    idx_l  = '0;
    valid  = 1'b0;
    winner = '0;
    // Scan farthest-first so the nearest requester after last is the final assignment.
    for (int k = NUM_M; k >= 1; k--) begin
      idx   = (int'(last) + k) % NUM_M;
      idx_l = IW'(idx);
      if (req[idx_l]) begin
        valid  = 1'b1;
        winner = idx_l;
      end
    end
  end

endmodule

// File: rtl/ahb_rr_arbiter_n.sv
// N-master / M-slave AHB arbiter with round-robin grant, pipelined muxing and default slave.
// Optional owner hold timeout enabled by defining ARB_HOLD_TIMEOUT_EN.
//
// state   | meaning
// ST_IDLE | no master granted, htrans forced IDLE
// ST_OWN  | hmaster owns the address phase
module ahb_rr_arbiter_n
  import ahb_arb_pkg::*;
#(
  parameter int          NUM_M    = 8,
  parameter int          NUM_S    = 8,
  parameter int          AW       = 32,
  parameter int          DW       = 32,
  parameter logic [15:0] BASE_HI  = 16'hF000,
  parameter int          MAX_HOLD = 16
) (
  input  logic                       HCLK,
  input  logic                       HRESET,
  input  logic [NUM_M-1:0]           m_busreq,
  input  logic [NUM_M*AW-1:0]        m_haddr,
  input  logic [NUM_M*2-1:0]         m_htrans,
  input  logic [NUM_M-1:0]           m_hwrite,
  input  logic [NUM_M*DW-1:0]        m_hwdata,
  output logic [NUM_M-1:0]           m_hgrant,
  output logic [$clog2(NUM_M)-1:0]   hmaster,
  output logic [NUM_S-1:0]           s_hsel,
  output logic [AW-1:0]              haddr,
  output logic [1:0]                 htrans,
  output logic                       hwrite,
  output logic [DW-1:0]              hwdata,
  input  logic [NUM_S*DW-1:0]        s_hrdata,
  input  logic [NUM_S-1:0]           s_hready,
  output logic [DW-1:0]              hrdata,
  output logic                       hready,
  output logic                       dec_err
);

  localparam int MW = $clog2(NUM_M);

  if (MW > MIDX_W || NUM_M < 2 || NUM_S < 1 || NUM_S > MAX_PORTS || MAX_HOLD < 1)
  begin : g_bad_cfg
    $error("ahb_rr_arbiter_n: parameter out of range");
  end

  arb_state_t        state;
  logic [MW-1:0]     last;
  logic [MW-1:0]     winner;
  logic              win_valid;
  logic              rearb;
  logic              timeout;
  logic              addr_active;
  logic [SIDX_W-1:0] dec_slave;
  logic [SIDX_W-1:0] dp_slave;
  logic [MW-1:0]     dp_master;
  logic              dp_unmapped;

  ahb_rr_picker #(.NUM_M(NUM_M), .IW(MW)) u_picker (
    .req    (m_busreq),
    .last   (last),
    .winner (winner),
    .valid  (win_valid)
  );

  assign haddr       = m_haddr[hmaster*AW +: AW];
  assign hwrite      = m_hwrite[hmaster];
  assign htrans      = (|m_hgrant) ? m_htrans[hmaster*2 +: 2] : HT_IDLE;
  assign addr_active = (htrans == HT_NONSEQ) || (htrans == HT_SEQ);

  always_comb begin
    s_hsel    = '0;
    dec_slave = SLV_NONE;
    for (int i = 0; i < NUM_S; i++) begin
      if (addr_active && (haddr[AW-1:AW-16] == BASE_HI + 16'(i))) begin
        s_hsel[i] = 1'b1;
        dec_slave = SIDX_W'(i);
      end
    end
  end

`ifdef ARB_HOLD_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold_cnt;

  // Only expire when someone else is waiting; a lone owner keeps the bus.
  assign timeout = (state == ST_OWN) && (int'(hold_cnt) + 1 >= MAX_HOLD) &&
                   (|(m_busreq & ~m_hgrant));

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      hold_cnt <= '0;
    end else if (rearb) begin
      hold_cnt <= '0;
    end else if (state == ST_OWN && hready && int'(hold_cnt) < MAX_HOLD) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign rearb = hready && ((state == ST_IDLE) || !m_busreq[hmaster] || timeout);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state    <= ST_IDLE;
      m_hgrant <= '0;
      hmaster  <= '0;
      last     <= MW'(NUM_M - 1);
    end else if (rearb) begin
      if (win_valid) begin
        state    <= ST_OWN;
        m_hgrant <= NUM_M'(1) << winner;
        hmaster  <= winner;
        last     <= winner;
      end else begin
        state    <= ST_IDLE;
        m_hgrant <= '0;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_master   <= '0;
      dp_slave    <= SLV_NONE;
      dp_unmapped <= 1'b0;
    end else if (hready) begin
      dp_master   <= hmaster;
      dp_slave    <= dec_slave;
      dp_unmapped <= addr_active && (dec_slave == SLV_NONE);
    end
  end

  assign hwdata  = m_hwdata[dp_master*DW +: DW];
  assign dec_err = dp_unmapped;

  // Default slave answers zero-wait with zero data.
  always_comb begin
    hready = 1'b1;
    hrdata = '0;
    for (int i = 0; i < NUM_S; i++) begin
      if (dp_slave == SIDX_W'(i)) begin
        hready = s_hready[i];
        hrdata = s_hrdata[i*DW +: DW];
      end
    end
  end

endmodule

// File: tb/tb_ahb_rr_arbiter_n.sv
// Directed scoreboard bench for ahb_rr_arbiter_n (8 masters, 8 slaves, MAX_HOLD=4).
module tb_ahb_rr_arbiter_n;

  logic         HCLK;
  logic         HRESET;
  logic [7:0]   m_busreq;
  logic [255:0] m_haddr;
  logic [15:0]  m_htrans;
  logic [7:0]   m_hwrite;
  logic [255:0] m_hwdata;
  logic [7:0]   m_hgrant;
  logic [2:0]   hmaster;
  logic [7:0]   s_hsel;
  logic [31:0]  haddr;
  logic [1:0]   htrans;
  logic         hwrite;
  logic [31:0]  hwdata;
  logic [255:0] s_hrdata;
  logic [7:0]   s_hready;
  logic [31:0]  hrdata;
  logic         hready;
  logic         dec_err;

  int checks = 0;
  int errors = 0;
  string       tag_q[$];
  logic [31:0] exp_q[$];

  ahb_rr_arbiter_n #(.NUM_M(8), .NUM_S(8), .AW(32), .DW(32),
                     .BASE_HI(16'hF000), .MAX_HOLD(4)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .m_busreq(m_busreq), .m_haddr(m_haddr), .m_htrans(m_htrans),
    .m_hwrite(m_hwrite), .m_hwdata(m_hwdata),
    .m_hgrant(m_hgrant), .hmaster(hmaster), .s_hsel(s_hsel),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hwdata(hwdata),
    .s_hrdata(s_hrdata), .s_hready(s_hready),
    .hrdata(hrdata), .hready(hready), .dec_err(dec_err)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic at_neg();
    @(negedge HCLK);
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL sb_underflow observed=%h expected=none", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  initial begin
    HRESET   = 1'b1;
    m_busreq = '0;
    m_haddr  = '0;
    m_htrans = '0;
    m_hwrite = '0;
    s_hready = '1;
    for (int i = 0; i < 8; i++) begin
      m_hwdata[i*32 +: 32] = 32'hDA7A_0000 | 32'(i);
      s_hrdata[i*32 +: 32] = 32'hD000_0000 | 32'(i);
    end
    // master 0 presents a transfer before it is granted: must be masked
    m_haddr[31:0] = 32'hF000_0000;
    m_htrans[1:0] = 2'b10;

    // reset state
    tick(); tick();
    push("rst_grant", 32'h0); push("rst_hmaster", 32'h0); push("rst_dec_err", 32'h0);
    push("rst_hready", 32'h1); push("rst_htrans", 32'h0); push("rst_hsel", 32'h0);
    at_neg();
    pop_chk(32'(m_hgrant)); pop_chk(32'(hmaster)); pop_chk(32'(dec_err));
    pop_chk(32'(hready));   pop_chk(32'(htrans));  pop_chk(32'(s_hsel));
    HRESET = 1'b0;

    // 1: single requester, grant one cycle later, release one cycle later
    tick(); m_busreq = 8'h01;
    push("t1_grant_pre", 32'h0);
    at_neg(); pop_chk(32'(m_hgrant));
    tick();
    push("t1_grant", 32'h01); push("t1_hmaster", 32'h0);
    push("t1_htrans", 32'h2); push("t1_hsel", 32'h01);
    at_neg();
    pop_chk(32'(m_hgrant)); pop_chk(32'(hmaster)); pop_chk(32'(htrans)); pop_chk(32'(s_hsel));
    tick(); m_busreq = 8'h00;
    push("t1_grant_hold", 32'h01); push("t1_hrdata", 32'hD000_0000);
    at_neg(); pop_chk(32'(m_hgrant)); pop_chk(hrdata);
    tick(); m_htrans[1:0] = 2'b00;
    push("t1_grant_rel", 32'h0);
    at_neg(); pop_chk(32'(m_hgrant));

    // 2: everyone requests, each owner drops after one transfer
    m_busreq = 8'hFF;
    begin
      int exp_k;
      exp_k = 1;
      for (int n = 0; n < 9; n++) begin
        tick(); m_busreq = 8'hFF;
        push("t2_grant", 32'h1 << exp_k); push("t2_hmaster", 32'(exp_k));
        at_neg(); pop_chk(32'(m_hgrant)); pop_chk(32'(hmaster));
        m_busreq[exp_k] = 1'b0;
        exp_k = (exp_k + 1) % 8;
      end
    end
    m_busreq = 8'h00;
    tick();
    push("t2_idle", 32'h0);
    at_neg(); pop_chk(32'(m_hgrant));

    // 3: owner 2 writes slave 3, which stalls three cycles
    tick();
    m_busreq = 8'h04;
    m_haddr[64 +: 32] = 32'hF003_0010;
    m_htrans[5:4] = 2'b10;
    m_hwrite[2] = 1'b1;
    s_hready[3] = 1'b0;
    tick();
    push("t3_grant", 32'h04); push("t3_hmaster", 32'h2); push("t3_haddr", 32'hF003_0010);
    push("t3_hwrite", 32'h1); push("t3_hsel", 32'h08); push("t3_hready_pre", 32'h1);
    at_neg();
    pop_chk(32'(m_hgrant)); pop_chk(32'(hmaster)); pop_chk(haddr);
    pop_chk(32'(hwrite));   pop_chk(32'(s_hsel));  pop_chk(32'(hready));
    tick();
    m_busreq = 8'h40;
    m_htrans[5:4] = 2'b00;
    for (int n = 0; n < 3; n++) begin
      push("t3_frz_grant", 32'h04); push("t3_frz_hmaster", 32'h2);
      push("t3_frz_hready", 32'h0); push("t3_frz_hwdata", 32'hDA7A_0002);
      at_neg();
      pop_chk(32'(m_hgrant)); pop_chk(32'(hmaster)); pop_chk(32'(hready)); pop_chk(hwdata);
      tick();
    end
    s_hready[3] = 1'b1;
    push("t3_rel_grant", 32'h04); push("t3_rel_hready", 32'h1); push("t3_rel_hrdata", 32'hD000_0003);
    at_neg(); pop_chk(32'(m_hgrant)); pop_chk(32'(hready)); pop_chk(hrdata);
    tick();
    push("t3_next_grant", 32'h40); push("t3_next_hmaster", 32'h6);
    at_neg(); pop_chk(32'(m_hgrant)); pop_chk(32'(hmaster));
    m_busreq = 8'h00;
    m_hwrite[2] = 1'b0;
    tick();
    push("t3_idle", 32'h0);
    at_neg(); pop_chk(32'(m_hgrant));

    // 4: master 1 reads an unmapped address
    tick();
    m_busreq = 8'h02;
    m_haddr[32 +: 32] = 32'h1234_0000;
    m_htrans[3:2] = 2'b10;
    tick();
    push("t4_grant", 32'h02); push("t4_hsel", 32'h0); push("t4_dec_err_pre", 32'h0);
    at_neg(); pop_chk(32'(m_hgrant)); pop_chk(32'(s_hsel)); pop_chk(32'(dec_err));
    m_busreq = 8'h00;
    tick();
    m_htrans[3:2] = 2'b00;
    push("t4_dec_err", 32'h1); push("t4_hready", 32'h1); push("t4_hrdata", 32'h0);
    at_neg(); pop_chk(32'(dec_err)); pop_chk(32'(hready)); pop_chk(hrdata);
    tick();
    push("t4_dec_err_end", 32'h0);
    at_neg(); pop_chk(32'(dec_err));

    // 5: masters 0 and 5 contend; hold timeout when built in
    tick(); m_busreq = 8'h01;
    tick(); m_busreq = 8'h21;
    for (int n = 0; n < 9; n++) begin
`ifdef ARB_HOLD_TIMEOUT_EN
      push("t5_grant", (n >= 4 && n < 8) ? 32'h20 : 32'h01);
`else
      push("t5_grant", 32'h01);
`endif
      at_neg(); pop_chk(32'(m_hgrant));
      tick();
    end
    m_busreq = 8'h00;
    tick();
    push("t5_idle", 32'h0);
    at_neg(); pop_chk(32'(m_hgrant));

    // 6: reset in the middle of master 4's burst, during a wait state
    tick();
    m_busreq = 8'h10;
    m_haddr[128 +: 32] = 32'hF001_0000;
    m_htrans[9:8] = 2'b10;
    tick();
    push("t6_grant", 32'h10);
    at_neg(); pop_chk(32'(m_hgrant));
    m_busreq = 8'h51;
    s_hready[1] = 1'b0;
    tick();
    m_haddr[128 +: 32] = 32'hF001_0004;
    m_htrans[9:8] = 2'b11;
    push("t6_grant_hold", 32'h10); push("t6_hready", 32'h0);
    at_neg(); pop_chk(32'(m_hgrant)); pop_chk(32'(hready));
    HRESET = 1'b1;
    tick();
    push("t6_rst_grant", 32'h0); push("t6_rst_hmaster", 32'h0);
    push("t6_rst_hready", 32'h1); push("t6_rst_dec_err", 32'h0);
    at_neg();
    pop_chk(32'(m_hgrant)); pop_chk(32'(hmaster)); pop_chk(32'(hready)); pop_chk(32'(dec_err));
    HRESET = 1'b0;
    tick();
    push("t6_first_grant", 32'h01); push("t6_first_hmaster", 32'h0);
    at_neg(); pop_chk(32'(m_hgrant)); pop_chk(32'(hmaster));

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
